// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/main-memory arbiter: block-sized request and
// response payloads plus the arbiter FSM state encoding.
package cache_mem_arbiter_pkg;
  localparam int ADDR_W        = 32;
  localparam int WORD_W        = 32;
  localparam int BLOCK_SIZE    = 4;
  localparam int NUM_CACHE_REQ = 2;

  typedef logic [BLOCK_SIZE-1:0][WORD_W-1:0] block_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              cs;
    logic              rw;
    block_t            data;
  } memory_request_t;

  typedef struct packed {
    logic   ack;
    block_t data;
  } memory_response_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_RELEASE} arb_state_t;
endpackage

// File: rtl/cache_mem_arbiter_rr_pick.sv
// Round-robin picker: first unmasked requester after the last grantee.
module rr_priority_pick #(
  parameter int N    = 2,
  parameter int LG_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [LG_W-1:0] last_i,
  input  logic [N-1:0]    mask_i,
  output logic [N-1:0]    gnt_o,
  output logic            vld_o
);
  int idx;

  // Search last+1, last+2, ... wrapping; the first eligible hit wins.
  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last_i) + i) % N;
      if (!vld_o && req_i[idx] && !mask_i[idx]) begin
        gnt_o[idx] = 1'b1;
        vld_o      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares a single main-memory port between NUM_REQ cache controllers.
// One transaction outstanding at a time, round-robin arbitration, response
// routed to the grantee only, watchdog forces completion on a missing ack.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = NUM_CACHE_REQ,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  memory_request_t  [NUM_REQ-1:0]       req_i,
  output memory_response_t [NUM_REQ-1:0]       rsp_o,
  output memory_request_t                      mem_req_o,
  input  memory_response_t                     mem_rsp_i,
  output logic             [NUM_REQ-1:0]       grant_o,
  output logic                                 busy_o,
  output logic                                 timeout_o
);
  localparam int LG_W = $clog2(NUM_REQ);
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_t                      state_q;
  logic [LG_W-1:0]                 last_q;
  logic [NUM_REQ-1:0]              grant_q;
  memory_request_t                 mem_req_q;
  memory_response_t [NUM_REQ-1:0]  rsp_q;
  logic                            timeout_q;
  logic [WD_W-1:0]                 wd_q;
  logic                            mask_q;   // first IDLE cycle after RELEASE

  logic [NUM_REQ-1:0] cs_vec, mask_vec, pick_gnt;
  logic               pick_vld;
  logic [LG_W-1:0]    widx;
  logic               wd_expire;

  // Candidate vector, and the previous grantee masked for one cycle because
  // it is still allowed to hold cs while it reacts to its ack.
  always_comb begin
    cs_vec   = '0;
    mask_vec = '0;
    for (int k = 0; k < NUM_REQ; k++) cs_vec[k] = req_i[k].cs;
    if (mask_q) mask_vec[last_q] = 1'b1;
  end

  rr_priority_pick #(.N(NUM_REQ), .LG_W(LG_W)) u_pick (
    .req_i  (cs_vec),
    .last_i (last_q),
    .mask_i (mask_vec),
    .gnt_o  (pick_gnt),
    .vld_o  (pick_vld)
  );

  // One-hot winner to index.
  always_comb begin
    widx = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (pick_gnt[k]) widx = LG_W'(k);
  end

  assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Arbiter FSM with all payload and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      last_q    <= LG_W'(NUM_REQ - 1);
      grant_q   <= '0;
      mem_req_q <= '0;
      rsp_q     <= '0;
      timeout_q <= 1'b0;
      wd_q      <= '0;
      mask_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          mask_q <= 1'b0;
          if (pick_vld) begin
            mem_req_q    <= req_i[widx];
            mem_req_q.cs <= 1'b1;
            grant_q      <= pick_gnt;
            last_q       <= widx;
            wd_q         <= '0;
            state_q      <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          wd_q <= wd_q + WD_W'(1);
          // A real ack takes precedence over a coincident watchdog expiry.
          if (mem_rsp_i.ack) begin
            rsp_q[last_q].ack  <= 1'b1;
            rsp_q[last_q].data <= mem_rsp_i.data;
            mem_req_q.cs       <= 1'b0;
            state_q            <= ARB_RELEASE;
          end else if (wd_expire) begin
            rsp_q[last_q].ack  <= 1'b1;
            rsp_q[last_q].data <= '0;
            mem_req_q.cs       <= 1'b0;
            timeout_q          <= 1'b1;
            state_q            <= ARB_RELEASE;
          end
        end
        ARB_RELEASE: begin
          rsp_q[last_q].ack <= 1'b0;
          grant_q           <= '0;
          wd_q              <= '0;
          mask_q            <= 1'b1;
          state_q           <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign rsp_o     = rsp_q;
  assign mem_req_o = mem_req_q;
  assign grant_o   = grant_q;
  assign busy_o    = (state_q != ARB_IDLE);
  assign timeout_o = timeout_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  logic                        clk, rst_n;
  memory_request_t  [1:0]      req;
  memory_response_t [1:0]      rsp;
  memory_request_t             mem_req;
  memory_response_t            mem_rsp;
  logic [1:0]                  grant;
  logic                        busy, tmo;
  int                          n_chk, n_err;

  cache_mem_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .rsp_o     (rsp),
    .mem_req_o (mem_req),
    .mem_rsp_i (mem_rsp),
    .grant_o   (grant),
    .busy_o    (busy),
    .timeout_o (tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = '0;
    mem_rsp = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic block_t fill(input logic [31:0] base);
    block_t b;
    for (int i = 0; i < BLOCK_SIZE; i++) b[i] = base + 32'(i);
    return b;
  endfunction

  memory_request_t exp_mr;
  logic [1:0]      exp_g;
  int              e;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    req = '0;
    mem_rsp = '0;

    // Reset state
    do_reset();
    chk("rst_memreq", 192'(mem_req), 192'(0));
    chk("rst_rsp0",   192'(rsp[0]),  192'(0));
    chk("rst_rsp1",   192'(rsp[1]),  192'(0));
    chk("rst_grant",  192'(grant),   192'(0));
    chk("rst_busy",   192'(busy),    192'(0));
    chk("rst_tmo",    192'(tmo),     192'(0));

    // 1: single read from requester 0, ack 3 cycles after the request
    req[0].addr = 32'h040;
    req[0].rw   = 1'b0;
    req[0].cs   = 1'b1;
    tick();
    chk("t1_memcs",  192'(mem_req.cs),   192'(1));
    chk("t1_addr",   192'(mem_req.addr), 192'(32'h040));
    chk("t1_grant",  192'(grant),        192'(2'b01));
    chk("t1_busy",   192'(busy),         192'(1));
    tick();
    tick();
    mem_rsp.ack  = 1'b1;
    mem_rsp.data = fill(32'h0);
    tick();
    mem_rsp.ack = 1'b0;
    chk("t1_ack0",   192'(rsp[0].ack),  192'(1));
    chk("t1_data0",  192'(rsp[0].data), 192'(fill(32'h0)));
    chk("t1_rsp1",   192'(rsp[1]),      192'(0));
    chk("t1_relgnt", 192'(grant),       192'(2'b01));
    chk("t1_memcs0", 192'(mem_req.cs),  192'(0));
    req[0].cs = 1'b0;
    tick();
    chk("t1_ackoff", 192'(rsp[0].ack),  192'(0));
    chk("t1_keep",   192'(rsp[0].data), 192'(fill(32'h0)));
    chk("t1_gnt0",   192'(grant),       192'(0));
    chk("t1_idle",   192'(busy),        192'(0));

    // 2: both requesting continuously -> strict rotation 0,1,0,1
    do_reset();
    req[0].addr = 32'h111;
    req[1].addr = 32'h222;
    req[0].cs   = 1'b1;
    req[1].cs   = 1'b1;
    for (int r = 0; r < 4; r++) begin
      e     = r % 2;
      exp_g = 2'(1 << e);
      tick();
      chk("t2_grant", 192'(grant),        192'(exp_g));
      chk("t2_busy",  192'(busy),         192'(1));
      chk("t2_addr",  192'(mem_req.addr), 192'(e == 0 ? 32'h111 : 32'h222));
      mem_rsp.ack  = 1'b1;
      mem_rsp.data = fill(32'h1000 * 32'(r + 1));
      tick();
      mem_rsp.ack = 1'b0;
      chk("t2_ack",   192'(rsp[e].ack),    192'(1));
      chk("t2_data",  192'(rsp[e].data),   192'(fill(32'h1000 * 32'(r + 1))));
      chk("t2_other", 192'(rsp[1-e].ack),  192'(0));
      tick();
      chk("t2_gap",   192'(busy),                      192'(0));
      chk("t2_noack", 192'({rsp[0].ack, rsp[1].ack}),  192'(0));
    end
    tick();
    chk("t2_resume", 192'(busy), 192'(1));

    // 3: requester 1 write held stable while requester 0 toggles cs
    do_reset();
    req[0].addr = 32'h200;
    req[1].addr = 32'hFE0;
    req[1].rw   = 1'b1;
    req[1].data = {BLOCK_SIZE{32'hA5A5A5A5}};
    req[1].cs   = 1'b1;
    exp_mr      = req[1];
    tick();
    chk("t3_grant", 192'(grant),   192'(2'b10));
    chk("t3_req",   192'(mem_req), 192'(exp_mr));
    for (int c = 0; c < 4; c++) begin
      req[0].cs      = ~req[0].cs;
      req[1].addr    = 32'h100 + 32'(c);
      req[1].data[0] = 32'(c);
      tick();
      chk("t3_hold", 192'(mem_req), 192'(exp_mr));
    end
    req[0].cs    = 1'b1;
    mem_rsp.ack  = 1'b1;
    mem_rsp.data = fill(32'h77);
    tick();
    mem_rsp.ack = 1'b0;
    req[1].cs   = 1'b0;
    chk("t3_ack1", 192'(rsp[1].ack), 192'(1));
    chk("t3_rsp0", 192'(rsp[0]),     192'(0));
    tick();
    tick();
    chk("t3_next",  192'(grant),        192'(2'b01));
    chk("t3_naddr", 192'(mem_req.addr), 192'(32'h200));

    // 4: watchdog forces completion after 8 WAIT cycles
    do_reset();
    req[0].addr = 32'h300;
    req[0].cs   = 1'b1;
    tick();
    mem_rsp.ack  = 1'b1;
    mem_rsp.data = fill(32'hBEEF0000);
    tick();
    mem_rsp.ack = 1'b0;
    chk("t4_pre", 192'(rsp[0].data), 192'(fill(32'hBEEF0000)));
    tick();
    chk("t4_idle1", 192'(busy), 192'(0));
    tick();
    chk("t4_mask",  192'(busy), 192'(0));
    tick();
    chk("t4_regnt", 192'(grant), 192'(2'b01));
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("t4_wait", 192'({rsp[0].ack, tmo, busy}), 192'(3'b001));
    end
    tick();
    chk("t4_ack",   192'(rsp[0].ack),  192'(1));
    chk("t4_tmo",   192'(tmo),         192'(1));
    chk("t4_data",  192'(rsp[0].data), 192'(0));
    chk("t4_memcs", 192'(mem_req.cs),  192'(0));
    req[0].cs   = 1'b0;
    req[1].addr = 32'h400;
    req[1].cs   = 1'b1;
    tick();
    chk("t4_tmo_off", 192'(tmo),        192'(0));
    chk("t4_ack_off", 192'(rsp[0].ack), 192'(0));
    chk("t4_idle",    192'(busy),       192'(0));
    tick();
    chk("t4_next", 192'(grant), 192'(2'b10));

    // 5: ack on the watchdog terminal cycle wins
    do_reset();
    req[0].cs = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    mem_rsp.ack  = 1'b1;
    mem_rsp.data = fill(32'hCAFE0000);
    tick();
    mem_rsp.ack = 1'b0;
    chk("t5_ack",  192'(rsp[0].ack),  192'(1));
    chk("t5_data", 192'(rsp[0].data), 192'(fill(32'hCAFE0000)));
    chk("t5_tmo",  192'(tmo),         192'(0));

    // 6: reset during WAIT aborts silently
    do_reset();
    req[1].addr = 32'h500;
    req[1].cs   = 1'b1;
    tick();
    chk("t6_grant", 192'(grant), 192'(2'b10));
    tick();
    rst_n        = 1'b0;
    mem_rsp.ack  = 1'b1;
    mem_rsp.data = fill(32'h1);
    tick();
    chk("t6_memreq", 192'(mem_req), 192'(0));
    chk("t6_rsp0",   192'(rsp[0]),  192'(0));
    chk("t6_rsp1",   192'(rsp[1]),  192'(0));
    chk("t6_flags",  192'({grant, busy, tmo}), 192'(0));
    rst_n       = 1'b1;
    mem_rsp.ack = 1'b0;
    req[0].cs   = 1'b1;
    tick();
    chk("t6_first", 192'(grant),      192'(2'b01));
    chk("t6_noack", 192'(rsp[1].ack), 192'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
